// File: rtl/br_pkg.sv
// Shared definitions for branch resolution: funct3 encodings and the 2-bit
// saturating counter type used by the branch history table.
package br_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Counter moves one step toward the observed outcome, pinned at SNT/ST.
    function automatic ctr_t sat_update(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        if (taken) begin
            if (c != ST) n = c + 2'd1;
        end else begin
            if (c != SNT) n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bht.sv
// Branch history table: DEPTH 2-bit saturating counters, one combinational
// read port for fetch and one saturating-update write port for resolve.
module bht
    import br_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output ctr_t             o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    ctr_t r_ctr [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctr[i] <= WNT;
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= sat_update(r_ctr[i_wr_idx], i_wr_taken);
        end
    end

    // No write-to-read bypass: a same-cycle update shows up next cycle.
    assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule

// File: rtl/br_resolve.sv
// Branch resolution and 2-bit-counter prediction unit. Optional performance
// counters are built when BR_PERF_CNT_EN is defined.
module br_resolve
    import br_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_if_pc,
    output logic        o_if_pred_taken,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic        i_ex_is_jal,
    input  logic        i_ex_is_jalr,
    input  logic [2:0]  i_ex_funct3,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    output logic        o_br_un,
    input  logic        i_brc_less,
    input  logic        i_brc_equal,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_illegal_br,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt
);

    logic w_is_jalr;
    logic w_is_jal;
    logic w_is_br;
    logic w_cond;
    logic w_taken;
    logic w_train;
    ctr_t w_if_ctr;
    logic w_unused_pc_bits;

    // i_ex_valid qualifies every resolve-stage input; with it low nothing
    // redirects, nothing is flagged and nothing trains. Kind priority is
    // JALR over JAL over conditional branch.
    assign w_is_jalr = i_ex_valid & i_ex_is_jalr;
    assign w_is_jal  = i_ex_valid & i_ex_is_jal & ~i_ex_is_jalr;
    assign w_is_br   = i_ex_valid & i_ex_is_br & ~i_ex_is_jal & ~i_ex_is_jalr;

    assign o_br_un = i_ex_funct3[1];

    always_comb begin
        w_cond       = 1'b0;
        o_illegal_br = 1'b0;
        case (i_ex_funct3)
            BEQ:     w_cond = i_brc_equal;
            BNE:     w_cond = ~i_brc_equal;
            BLT:     w_cond = i_brc_less;
            BGE:     w_cond = ~i_brc_less;
            BLTU:    w_cond = i_brc_less;
            BGEU:    w_cond = ~i_brc_less;
            default: o_illegal_br = w_is_br;
        endcase
    end

    always_comb begin
        w_taken    = 1'b0;
        o_redirect = 1'b0;
        if (w_is_jalr) begin
            w_taken    = 1'b1;
            o_redirect = 1'b1;
        end else if (w_is_jal) begin
            w_taken    = 1'b1;
            o_redirect = ~i_ex_pred_taken;
        end else if (w_is_br) begin
            w_taken    = w_cond;
            o_redirect = w_cond ^ i_ex_pred_taken;
        end
    end

    assign o_redirect_pc = w_taken ? i_ex_target : i_ex_pc + 32'd4;

    assign w_train = w_is_br & ~o_illegal_br;

    bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rd_idx   (i_if_pc[IDX_W+1:2]),
        .o_rd_ctr   (w_if_ctr),
        .i_wr_en    (w_train),
        .i_wr_idx   (i_ex_pc[IDX_W+1:2]),
        .i_wr_taken (w_taken)
    );

    assign o_if_pred_taken = w_if_ctr[1];

    assign w_unused_pc_bits = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0], w_if_ctr[0]};

`ifdef BR_PERF_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_br_cnt      <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            if (w_is_jalr | w_is_jal | w_is_br) r_br_cnt <= r_br_cnt + 32'd1;
            if (o_redirect) r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign o_br_cnt      = r_br_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
`else
    assign o_br_cnt      = 32'd0;
    assign o_mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve: reference outcome model feeding an
// expected queue, plus a shadow counter table and perf-counter model.
module tb_br_resolve;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_if_pc;
    logic        o_if_pred_taken;
    logic        i_ex_valid;
    logic        i_ex_is_br;
    logic        i_ex_is_jal;
    logic        i_ex_is_jalr;
    logic [2:0]  i_ex_funct3;
    logic [31:0] i_ex_pc;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic        o_br_un;
    logic        i_brc_less;
    logic        i_brc_equal;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_illegal_br;
    logic [31:0] o_br_cnt;
    logic [31:0] o_mispred_cnt;

    br_resolve dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_if_pc         (i_if_pc),
        .o_if_pred_taken (o_if_pred_taken),
        .i_ex_valid      (i_ex_valid),
        .i_ex_is_br      (i_ex_is_br),
        .i_ex_is_jal     (i_ex_is_jal),
        .i_ex_is_jalr    (i_ex_is_jalr),
        .i_ex_funct3     (i_ex_funct3),
        .i_ex_pc         (i_ex_pc),
        .i_ex_target     (i_ex_target),
        .i_ex_pred_taken (i_ex_pred_taken),
        .o_br_un         (o_br_un),
        .i_brc_less      (i_brc_less),
        .i_brc_equal     (i_brc_equal),
        .o_redirect      (o_redirect),
        .o_redirect_pc   (o_redirect_pc),
        .o_illegal_br    (o_illegal_br),
        .o_br_cnt        (o_br_cnt),
        .o_mispred_cnt   (o_mispred_cnt)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- scoreboard state ----------------
    int          n_checks;
    int          n_errors;
    logic [34:0] exp_q[$];   // {redirect, illegal, br_un, redirect_pc}
    logic [34:0] got;
    logic [34:0] exp_v;
    logic [1:0]  m_bht[64];
    logic [31:0] m_br_cnt;
    logic [31:0] m_mis_cnt;
    logic        p_train;
    logic        p_taken;
    logic        p_any;
    logic        p_redir;
    logic [5:0]  p_idx;

    function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef BR_PERF_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_br_cnt  = 32'd0;
        m_mis_cnt = 32'd0;
        p_train   = 1'b0;
        p_any     = 1'b0;
        p_redir   = 1'b0;
    endtask

    task automatic clock_step();
        @(posedge i_clk);
        if (!i_rst) begin
            if (p_train) begin
                if (p_taken && m_bht[p_idx] != 2'b11) m_bht[p_idx] = m_bht[p_idx] + 2'd1;
                if (!p_taken && m_bht[p_idx] != 2'b00) m_bht[p_idx] = m_bht[p_idx] - 2'd1;
            end
            if (p_any) m_br_cnt = m_br_cnt + 32'd1;
            if (p_redir) m_mis_cnt = m_mis_cnt + 32'd1;
        end
        p_train = 1'b0;
        p_any   = 1'b0;
        p_redir = 1'b0;
        #1;
        i_ex_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clock_step();
        i_rst = 1'b0;
        model_reset();
    endtask

    // Drives one resolve and pushes the reference result; leaves the clock alone.
    task automatic drive_resolve(input logic v, input logic br, input logic jal,
                                 input logic jalr, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic pred, input logic less, input logic eq);
        logic j, jl, b, ill, cond, tk, rd;
        i_ex_valid      = v;
        i_ex_is_br      = br;
        i_ex_is_jal     = jal;
        i_ex_is_jalr    = jalr;
        i_ex_funct3     = f3;
        i_ex_pc         = pc;
        i_ex_target     = tgt;
        i_ex_pred_taken = pred;
        i_brc_less      = less;
        i_brc_equal     = eq;
        j  = v & jalr;
        jl = v & jal & !jalr;
        b  = v & br & !jal & !jalr;
        ill = b & ((f3 == 3'b010) || (f3 == 3'b011));
        case (f3)
            3'b000: cond = eq;
            3'b001: cond = !eq;
            3'b100, 3'b110: cond = less;
            3'b101, 3'b111: cond = !less;
            default: cond = 1'b0;
        endcase
        tk = j | jl | (b & cond);
        rd = j | ((jl | b) & (tk ^ pred));
        exp_q.push_back({rd, ill, f3[1], (tk ? tgt : pc + 32'd4)});
        p_train = b & !ill;
        p_taken = tk;
        p_idx   = pc[7:2];
        p_any   = j | jl | b;
        p_redir = rd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // A taken resolve during reset must not train.
        i_if_pc = 32'h40;
        drive_resolve(1, 1, 0, 0, 3'b000, 32'h40, 32'h0, 0, 0, 1);
        void'(exp_q.pop_front());
        i_rst = 1'b1;
        clock_step();
        i_rst = 1'b0;
        model_reset();
        for (int a = 0; a < 64; a++) begin
            i_if_pc = 32'(a * 4);
            #1;
            n_checks++;
            if (o_if_pred_taken !== 1'b0)
                $display("FAIL reset_pred pc=%h got=%b exp=0", i_if_pc, o_if_pred_taken);
            if (o_if_pred_taken !== 1'b0) n_errors++;
        end
        n_checks++;
        if (o_br_cnt !== 32'd0 || o_mispred_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_perf got=%0d/%0d exp=0/0", o_br_cnt, o_mispred_cnt);
        end
    endtask

    task automatic test_signed_unsigned();
        drive_resolve(1, 1, 0, 0, 3'b100, 32'h100, 32'h80, 0, 1, 0);
        #1;
        got = {o_redirect, o_illegal_br, o_br_un, o_redirect_pc};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL blt got=%h exp=%h", got, exp_v);
        end
        clock_step();
        drive_resolve(1, 1, 0, 0, 3'b111, 32'h100, 32'h80, 0, 1, 0);
        #1;
        got = {o_redirect, o_illegal_br, o_br_un, o_redirect_pc};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL bgeu got=%h exp=%h", got, exp_v);
        end
        clock_step();
    endtask

    task automatic test_same_cycle();
        i_if_pc = 32'h40;
        drive_resolve(1, 1, 0, 0, 3'b000, 32'h40, 32'h10, 0, 0, 1);
        #1;
        n_checks++;
        if (o_if_pred_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL same_cycle_now got=%b exp=0", o_if_pred_taken);
        end
        got = {o_redirect, o_illegal_br, o_br_un, o_redirect_pc};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL same_cycle_res got=%h exp=%h", got, exp_v);
        end
        clock_step();
        n_checks++;
        if (o_if_pred_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL same_cycle_next got=%b exp=1", o_if_pred_taken);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_ctr [5] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
        i_if_pc = 32'h40;
        for (int k = 0; k < 5; k++) begin
            drive_resolve(1, 1, 0, 0, 3'b000, 32'h40, 32'h200, m_bht[16][1], 0, (k < 4));
            #1;
            got = {o_redirect, o_illegal_br, o_br_un, o_redirect_pc};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL sat_res k=%0d got=%h exp=%h", k, got, exp_v);
            end
            clock_step();
            n_checks++;
            if (m_bht[16] !== exp_ctr[k] || o_if_pred_taken !== exp_ctr[k][1]) begin
                n_errors++;
                $display("FAIL sat_pred k=%0d got=%b exp=%b", k, o_if_pred_taken, exp_ctr[k][1]);
            end
        end
    endtask

    task automatic test_jumps();
        // JAL with is_br also set (JAL wins, branch would be not-taken).
        i_if_pc = 32'h60;
        drive_resolve(1, 1, 1, 0, 3'b000, 32'h60, 32'h1000, 1, 0, 0);
        #1;
        got = {o_redirect, o_illegal_br, o_br_un, o_redirect_pc};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL jal got=%h exp=%h", got, exp_v);
        end
        clock_step();
        drive_resolve(1, 1, 1, 1, 3'b000, 32'h60, 32'h2000, 0, 0, 0);
        #1;
        got = {o_redirect, o_illegal_br, o_br_un, o_redirect_pc};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL jalr got=%h exp=%h", got, exp_v);
        end
        clock_step();
        drive_resolve(1, 1, 0, 0, 3'b000, 32'h60, 32'h0, 0, 0, 0);
        void'(exp_q.pop_front());
        i_ex_valid = 1'b0;
        p_train = 1'b0;
        p_any = 1'b0;
        p_redir = 1'b0;
        #1;
        n_checks++;
        if (o_if_pred_taken !== m_bht[24][1] || m_bht[24] !== 2'b01) begin
            n_errors++;
            $display("FAIL jump_bht got=%b exp=0", o_if_pred_taken);
        end
    endtask

    task automatic test_illegal_perf();
        do_reset();
        i_if_pc = 32'h44;
        drive_resolve(1, 1, 0, 0, 3'b010, 32'h44, 32'h400, 1, 1, 1);
        #1;
        got = {o_redirect, o_illegal_br, o_br_un, o_redirect_pc};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL illegal got=%h exp=%h", got, exp_v);
        end
        clock_step();
        n_checks++;
        if (o_if_pred_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_train got=%b exp=0", o_if_pred_taken);
        end
        n_checks++;
        if (o_br_cnt !== exp_perf(32'd1) || o_mispred_cnt !== exp_perf(32'd1)) begin
            n_errors++;
            $display("FAIL illegal_perf got=%0d/%0d exp=%0d/%0d", o_br_cnt, o_mispred_cnt,
                     exp_perf(32'd1), exp_perf(32'd1));
        end
        // Invalid slot: nothing flagged, nothing redirected.
        drive_resolve(0, 1, 0, 1, 3'b011, 32'h44, 32'h400, 1, 1, 1);
        #1;
        got = {o_redirect, o_illegal_br, o_br_un, o_redirect_pc};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got[34:33] !== exp_v[34:33] || got[32] !== exp_v[32]) begin
            n_errors++;
            $display("FAIL invalid got=%h exp=%h", got, exp_v);
        end
        clock_step();
        // PC wrap on the fall-through path.
        drive_resolve(1, 1, 0, 0, 3'b001, 32'hFFFF_FFFC, 32'h8, 1, 0, 1);
        #1;
        got = {o_redirect, o_illegal_br, o_br_un, o_redirect_pc};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL pc_wrap got=%h exp=%h", got, exp_v);
        end
        clock_step();
    endtask

    task automatic test_back_to_back();
        logic [2:0] kind;
        for (int n = 0; n < 200; n++) begin
            kind = 3'($urandom_range(0, 7));
            i_if_pc = 32'($urandom_range(0, 63) * 4);
            drive_resolve(($urandom_range(0, 9) != 0), (kind < 5) | kind[0], (kind == 5),
                          (kind == 6), 3'($urandom_range(0, 7)),
                          32'($urandom_range(0, 63) * 4), $urandom() & 32'hFFFF_FFFE,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            #1;
            got = {o_redirect, o_illegal_br, o_br_un, o_redirect_pc};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL b2b_res n=%0d got=%h exp=%h", n, got, exp_v);
            end
            clock_step();
            n_checks++;
            if (o_if_pred_taken !== m_bht[i_if_pc[7:2]][1]) begin
                n_errors++;
                $display("FAIL b2b_pred n=%0d pc=%h got=%b exp=%b", n, i_if_pc,
                         o_if_pred_taken, m_bht[i_if_pc[7:2]][1]);
            end
            n_checks++;
            if (o_br_cnt !== exp_perf(m_br_cnt) || o_mispred_cnt !== exp_perf(m_mis_cnt)) begin
                n_errors++;
                $display("FAIL b2b_perf n=%0d got=%0d/%0d exp=%0d/%0d", n, o_br_cnt,
                         o_mispred_cnt, exp_perf(m_br_cnt), exp_perf(m_mis_cnt));
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks        = 0;
        n_errors        = 0;
        i_rst           = 1'b1;
        i_if_pc         = 32'h0;
        i_ex_valid      = 1'b0;
        i_ex_is_br      = 1'b0;
        i_ex_is_jal     = 1'b0;
        i_ex_is_jalr    = 1'b0;
        i_ex_funct3     = 3'b000;
        i_ex_pc         = 32'h0;
        i_ex_target     = 32'h0;
        i_ex_pred_taken = 1'b0;
        i_brc_less      = 1'b0;
        i_brc_equal     = 1'b0;
        model_reset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        test_reset();
        test_signed_unsigned();
        do_reset();
        test_same_cycle();
        do_reset();
        test_saturation();
        test_jumps();
        test_illegal_perf();
        do_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/br_resolve.md
# br_resolve

Branch resolution and prediction unit for the RISC-V core. Drives the branch comparator's unsigned-select input from the resolving instruction's funct3 and consumes its `less`/`equal` flags. Decides the actual branch outcome, compares it with the fetch-time prediction, and issues a PC redirect on mismatch. Holds a table of 2-bit saturating counters that provides the fetch-stage prediction and is trained at resolve.

## Interface

**Parameters**
- `BHT_DEPTH`, 64: number of 2-bit counters; power of two, ≥ 2.
- `IDX_W`, $clog2(BHT_DEPTH): index width, taken from PC[IDX_W+1:2].

**Ports**
- `i_clk` input 1: clock; single clock domain.
- `i_rst` input 1: reset; synchronous, active-high.
- `i_if_pc` input 32: fetch PC for the prediction lookup.
- `o_if_pred_taken` output 1: counter[idx(i_if_pc)][1].
- `i_ex_valid` input 1: resolve-stage instruction is valid.
- `i_ex_is_br` input 1: conditional branch.
- `i_ex_is_jal` input 1: JAL.
- `i_ex_is_jalr` input 1: JALR.
- `i_ex_funct3` input 3: branch funct3.
- `i_ex_pc` input 32: PC of the resolving instruction.
- `i_ex_target` input 32: computed target (PC+imm, or rs1+imm with bit0 cleared).
- `i_ex_pred_taken` input 1: prediction carried from fetch.
- `o_br_un` output 1: to comparator; equals i_ex_funct3[1].
- `i_brc_less` input 1: comparator less flag.
- `i_brc_equal` input 1: comparator equal flag.
- `o_redirect` output 1: flush younger stages and load o_redirect_pc.
- `o_redirect_pc` output 32: corrected next PC.
- `o_illegal_br` output 1: branch with funct3 010/011.
- `o_br_cnt` output 32: resolved-control-transfer count (BR_PERF_CNT_EN only).
- `o_mispred_cnt` output 32: redirect count (BR_PERF_CNT_EN only).

## Operation

**Outcome (combinational; gated by i_ex_valid)**
- BEQ 000: equal. BNE 001: !equal. BLT 100 / BLTU 110: less. BGE 101 / BGEU 111: !less.
- 010/011: taken=0, o_illegal_br=1.
- JAL and JALR: taken=1.

**Redirect**
- Branch, or JAL: o_redirect = taken ^ i_ex_pred_taken.
- JALR: o_redirect=1 always; there is no target prediction.
- o_redirect_pc = taken ? i_ex_target : i_ex_pc+4, with 32-bit wrap.
- When o_redirect=0, o_redirect_pc is don't-care but is still driven.

**Training**
- Happens on the clock edge, only when i_ex_valid & i_ex_is_br & !o_illegal_br.
- Counter at idx(i_ex_pc): increment on taken, saturating at 11; decrement on not-taken, saturating at 00.
- Jumps and illegal branches leave the table untouched.

**Precedence and defaults**
- Multiple is_* set simultaneously: JALR > JAL > branch.
- When i_ex_valid=0: o_redirect=0, o_illegal_br=0, no update.

## Timing

- o_if_pred_taken: combinational from i_if_pc and the registered table; no bypass. A same-cycle update to the same index is visible to the lookup on the next cycle.
- o_br_un, outcome, o_redirect, o_redirect_pc, o_illegal_br: combinational within the resolve cycle (zero latency).
- Counter update and perf counters: visible the cycle after the resolve.

**Reset**
- Every counter is set to 01 (weakly not-taken), so o_if_pred_taken=0.
- o_br_cnt and o_mispred_cnt are set to 0.
- Combinational outputs follow their inputs.
- Reset asserted in the same cycle as a resolve: reset wins and no training occurs.

## Configuration

- Macro: `BR_PERF_CNT_EN`.
- **Defined:**
  - o_br_cnt increments on every valid branch or jump, including illegal.
  - o_mispred_cnt increments whenever o_redirect=1.
  - Both wrap modulo 2^32.
- **Undefined:** both ports tie to 0 and the counter flops are not built.

## Structure

**Shared package `br_pkg`**
- funct3 localparams: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- 2-bit counter typedef.
- Counter constants: SNT=00, WNT=01, WT=10, ST=11.

**Sub-module `bht`**
- Counter array.
- Synchronous reset.
- One combinational read port (fetch).
- One write port that performs the saturating update at resolve.

br_resolve instantiates `bht` and contains the outcome/redirect logic plus the optional counters.

## Test plan

- **Reset:** assert i_rst 1 cycle, then sweep i_if_pc over 0x0–0xFC → o_if_pred_taken=0 at every index; perf counters 0.
- **Signed vs unsigned:** BLT funct3=100, less=1, pred=0, pc=0x100, target=0x80 → o_br_un=0, o_redirect=1, o_redirect_pc=0x80.
  - Then BGEU 111, less=1, pred=0 → o_br_un=1, o_redirect=0.
- **Saturation:** four taken BEQ at pc=0x40 → counter goes 01→10→11→11, o_if_pred_taken(0x40)=1.
  - Then one not-taken → 10, still predicting taken.
- **Same-cycle conflict:** lookup i_if_pc=0x40 in the same cycle as a taken resolve at 0x40 with counter at 01 → o_if_pred_taken=0 that cycle, 1 the next.
- **Jumps:**
  - JAL with pred=1 → no redirect.
  - JALR target 0x2000 → o_redirect=1, o_redirect_pc=0x2000.
  - BHT unchanged in both cases.
- **Illegal and perf counters:** funct3=010 branch with pred=1 → o_illegal_br=1, taken=0, o_redirect=1, o_redirect_pc=pc+4, no training.
  - With BR_PERF_CNT_EN defined → o_br_cnt=1, o_mispred_cnt=1.
